if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- IF-stage producer that drives the write side of the IF/ID pipeline register.
- Holds the PC and fetches words from instruction memory over a ready-qualified request interface.
- Keeps a one-entry fetch buffer and presents IF_Instruction/IF_PCadd4 with the matching IF_ID_Wre/IF_ID_Flush controls.
- Honours stalls from the hazard unit (PCWre=0) and branch/jump redirects from ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, word presented on IF_Instruction when no valid fetch is buffered

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
PCWre  input  1  1 = downstream may advance; 0 = load-use stall, hold IF/ID
Redirect  input  1  taken branch/jump this cycle; discard the fetch path
RedirectPC  input  32  target address, valid while Redirect=1
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, always word-aligned (bits [1:0]=00)
imem_ready  input  1  memory completes the request this cycle; imem_rdata valid
imem_rdata  input  32  fetched instruction word
IF_Instruction  output  32  instruction toward IF/ID
IF_PCadd4  output  32  address of IF_Instruction + 4
IF_ID_Wre  output  1  IF/ID write enable
IF_ID_Flush  output  1  IF/ID clears to NOP on write
PC  output  32  current fetch PC (debug)

Behaviour:
- State: PC register; fetch buffer (buf_valid, buf_instr, buf_pc4); FSM {IDLE, RUN}.
- Reset: PC=RESET_PC, buf_valid=0, buf_instr=NOP_INSTR, buf_pc4=0, state=IDLE. Reset overrides all other inputs.
- Outputs in IDLE: imem_req=0, IF_ID_Wre=0, IF_ID_Flush=0.
- IDLE -> RUN unconditionally one cycle after reset deasserts. No return to IDLE except by Reset.
- In RUN:
  - consume = buf_valid & PCWre & ~Redirect
  - imem_req = ~Redirect & (~buf_valid | consume)
  - imem_addr = PC
  - fill = imem_req & imem_ready
- Memory protocol:
  - Memory samples imem_addr only in a cycle where imem_ready=1, and returns data in that same cycle.
  - The block may change imem_addr or drop imem_req before ready. An unfinished request is abandoned, with no response owed.
- IF_ID_Wre = PCWre | Redirect (RUN only).
- IF_ID_Flush = Redirect | (PCWre & ~buf_valid), i.e. redirect squash or bubble insertion when no fetched word is available.
- Output data:
  - IF_Instruction = buf_valid ? buf_instr : NOP_INSTR
  - IF_PCadd4 = buf_pc4
- Next-state priority: Reset > Redirect > fill > consume.
  - Redirect: PC <= {RedirectPC[31:2],2'b00}; buf_valid <= 0. No fetch this cycle.
  - fill: buf_instr <= imem_rdata; buf_pc4 <= PC+4; buf_valid <= 1; PC <= PC+4. Fill and consume in the same cycle is allowed: buffer replaced, stays valid.
  - consume without fill: buf_valid <= 0.
  - Otherwise: hold everything.
- Stall (PCWre=0, buffer full): imem_req=0, PC and buffer frozen for any number of cycles, IF_ID_Wre=0.
- Throughput: with imem_ready tied 1 and PCWre=1, one instruction per cycle; first valid word reaches IF/ID input 2 cycles after reset release.
- Redirect wins over a simultaneous imem_ready: returned data is dropped and PC is not incremented.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Test Plan:
1. Reset=1 two cycles then 0, imem_ready=1, imem_rdata = addr+32'h100, PCWre=1 -> IDLE one cycle; then imem_addr 0,4,8; IF_Instruction 32'h100,32'h104 with IF_PCadd4 4,8; IF_ID_Flush=1 only in the first RUN cycle (bubble).
2. Steady fetch, then PCWre=0 for 3 cycles while buffer holds 32'h108 -> imem_req=0, IF_ID_Wre=0, PC=12 frozen, IF_Instruction stays 32'h108; PCWre=1 -> next word 32'h10C fetched, no word lost or duplicated.
3. Redirect=1 with RedirectPC=32'h0000_0043 in the same cycle as imem_ready=1 -> IF_ID_Flush=1, IF_ID_Wre=1, imem_req=0, data dropped; next cycle imem_addr=32'h40, buf_valid=0.
4. imem_ready held 0 for 4 cycles at PC=16 with PCWre=1 -> IF_ID_Flush=1 bubble each cycle, imem_addr stays 16; ready=1 -> buffer = word@16, IF_PCadd4=20.
5. Reset=1 mid-stall with a valid buffer -> next cycle PC=RESET_PC, buf_valid=0, IF_Instruction=NOP_INSTR, all handshake outputs 0.
6. Redirect to 32'hFFFF_FFFC then fill -> IF_PCadd4=0, PC=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the PC, fetches over a ready-qualified memory port,
// and feeds the IF/ID register from a one-entry buffer.
//   state | meaning
//   IDLE  | first cycle after reset, no fetch, IF/ID untouched
//   RUN   | fetching and presenting words to IF/ID
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCadd4,
  output logic        IF_ID_Wre,
  output logic        IF_ID_Flush,
  output logic [31:0] PC
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;

  logic        run;
  logic        consume;
  logic        fill;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = RedirectPC & 32'hFFFF_FFFC;

  always_comb begin
    run      = (state_q == ST_RUN);
    consume  = run & buf_valid_q & PCWre & ~Redirect;
    // A request is only raised when the buffer has room for the answer.
    imem_req = run & ~Redirect & (~buf_valid_q | consume);
    fill     = imem_req & imem_ready;
    pc_plus4 = pc_q + 32'd4;

    state_d     = ST_RUN;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;

    if (run) begin
      if (Redirect) begin
        pc_d        = redirect_aligned;
        buf_valid_d = 1'b0;
      end else if (fill) begin
        buf_instr_d = imem_rdata;
        buf_pc4_d   = pc_plus4;
        buf_valid_d = 1'b1;
        pc_d        = pc_plus4;
      end else if (consume) begin
        buf_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  assign imem_addr      = pc_q;
  assign PC             = pc_q;
  assign IF_Instruction = buf_valid_q ? buf_instr_q : NOP_INSTR;
  assign IF_PCadd4      = buf_pc4_q;
  assign IF_ID_Wre      = run & (PCWre | Redirect);
  // Flush either squashes on redirect or inserts a bubble when nothing is buffered.
  assign IF_ID_Flush    = run & (Redirect | (PCWre & ~buf_valid_q));

endmodule
